// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over the shared open-drain lines.
// Optional frame watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iSend,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic       oPS2_CLK_LOW,
    output logic       oPS2_DATA_LOW,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError,
    output logic       oRxInhibit
);
    // state     | meaning
    // IDLE      | lines released, waiting for iSend
    // INHIBIT   | host holds clock low
    // REQ       | start bit: data and clock low for one cycle
    // BITS      | data bits 0..7 then parity, one per device fall
    // STOP      | release data for the stop bit
    // ACK       | sample device ACK on the next fall
    // WAIT_IDLE | wait for both lines high, then oDone
    // ERR       | pulse oError, release lines
    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_BITS, S_STOP, S_ACK, S_WAIT_IDLE, S_ERR
    } state_t;

    localparam int CNT_W = $clog2(INHIBIT_CYCLES + 1);

    if (FILTER_LEN < 2 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("ps2_host_tx: invalid parameter values");
    end

    state_t             state_q;
    logic [8:0]         shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         bit_idx_q;
    logic               clk_low_q, data_low_q, busy_q, done_q, error_q;

    logic [1:0]            clk_sync_q, data_sync_q;
    logic [FILTER_LEN-1:0] clk_sh_q, data_sh_q;
    logic                  clk_flt_q, data_flt_q, clk_prev_q;
    logic                  clk_flt_d, data_flt_d;
    logic                  fall;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_q;
`endif

    // Filtered level only moves when the whole window agrees.
    always_comb begin
        clk_flt_d  = clk_flt_q;
        data_flt_d = data_flt_q;
        if (&clk_sh_q)       clk_flt_d = 1'b1;
        else if (~|clk_sh_q) clk_flt_d = 1'b0;
        if (&data_sh_q)       data_flt_d = 1'b1;
        else if (~|data_sh_q) data_flt_d = 1'b0;
    end

    assign fall = clk_prev_q & ~clk_flt_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_sh_q    <= '1;
            data_sh_q   <= '1;
            clk_flt_q   <= 1'b1;
            data_flt_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], iPS2_CLK};
            data_sync_q <= {data_sync_q[0], iPS2_DATA};
            clk_sh_q    <= {clk_sh_q[FILTER_LEN-2:0], clk_sync_q[1]};
            data_sh_q   <= {data_sh_q[FILTER_LEN-2:0], data_sync_q[1]};
            clk_flt_q   <= clk_flt_d;
            data_flt_q  <= data_flt_d;
            clk_prev_q  <= clk_flt_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    clk_low_q  <= 1'b0;
                    data_low_q <= 1'b0;
                    if (iSend) begin
                        shift_q   <= {~^iData, iData};
                        cnt_q     <= CNT_W'(INHIBIT_CYCLES - 1);
                        bit_idx_q <= '0;
                        busy_q    <= 1'b1;
                        clk_low_q <= 1'b1;
                        state_q   <= S_INHIBIT;
`ifdef PS2_TX_TIMEOUT_EN
                        wd_q      <= WD_W'(TIMEOUT_CYCLES - 2);
`endif
                    end
                end
                S_INHIBIT: begin
                    if (cnt_q == '0) begin
                        data_low_q <= 1'b1;
                        state_q    <= S_REQ;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_REQ: begin
                    clk_low_q <= 1'b0;
                    state_q   <= S_BITS;
                end
                S_BITS: begin
                    if (fall) begin
                        data_low_q <= ~shift_q[0];
                        shift_q    <= {1'b0, shift_q[8:1]};
                        if (bit_idx_q == 4'd8) state_q <= S_STOP;
                        else                   bit_idx_q <= bit_idx_q + 4'd1;
                    end
                end
                S_STOP: begin
                    if (fall) begin
                        data_low_q <= 1'b0;
                        state_q    <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (fall) state_q <= data_flt_q ? S_ERR : S_WAIT_IDLE;
                end
                S_WAIT_IDLE: begin
                    if (clk_flt_q && data_flt_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_ERR: begin
                    error_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    clk_low_q  <= 1'b0;
                    data_low_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            // Expiry one cycle early so the ERR pulse lands exactly TIMEOUT_CYCLES after acceptance.
            if (state_q != S_IDLE && state_q != S_ERR) begin
                if (wd_q == '0) begin
                    state_q    <= S_ERR;
                    clk_low_q  <= 1'b0;
                    data_low_q <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b1;
                end else begin
                    wd_q <= wd_q - WD_W'(1);
                end
            end
`endif
        end
    end

    assign oPS2_CLK_LOW  = clk_low_q;
    assign oPS2_DATA_LOW = data_low_q;
    assign oBusy         = busy_q;
    assign oDone         = done_q;
    assign oError        = error_q;
    assign oRxInhibit    = busy_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: wired-AND line model plus a behavioural PS/2 device that clocks frames in.
module tb_ps2_host_tx;
    localparam int INH  = 60;
    localparam int FLT  = 4;
    localparam int TMO  = 3000;
    localparam int HALF = 40;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iSend = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       iPS2_CLK, iPS2_DATA;
    logic       oPS2_CLK_LOW, oPS2_DATA_LOW, oBusy, oDone, oError, oRxInhibit;

    assign iPS2_CLK  = ~(oPS2_CLK_LOW | dev_clk_low);
    assign iPS2_DATA = ~(oPS2_DATA_LOW | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
        .Clock(Clock), .Reset(Reset), .iData(iData), .iSend(iSend),
        .iPS2_CLK(iPS2_CLK), .iPS2_DATA(iPS2_DATA),
        .oPS2_CLK_LOW(oPS2_CLK_LOW), .oPS2_DATA_LOW(oPS2_DATA_LOW),
        .oBusy(oBusy), .oDone(oDone), .oError(oError), .oRxInhibit(oRxInhibit)
    );

    always #10 Clock = ~Clock;

    int errors = 0;
    int checks = 0;
    int done_cnt, err_cnt, busy_after;
    bit seen_pulse;
    int g_both = 0, g_pbusy = 0, g_rxinh = 0;

    logic [9:0] f_bits;
    logic       f_start;
    int         f_inh_bad;
    logic       f_rst_clk, f_rst_data, f_rst_busy;

    // Expected line frame {stop, parity, data, start} from the protocol rules.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
        if (seen_pulse && oBusy) busy_after++;
        if (oDone) done_cnt++;
        if (oError) err_cnt++;
        if (oDone && oError) g_both++;
        if ((oDone || oError) && oBusy) g_pbusy++;
        if (oRxInhibit !== oBusy) g_rxinh++;
        if (oDone || oError) seen_pulse = 1'b1;
    endtask

    task automatic clear_mon();
        done_cnt = 0; err_cnt = 0; busy_after = 0; seen_pulse = 1'b0;
    endtask

    // mode 0: plain frame, 1: extra iSend mid-frame, 2: reset during BITS
    task automatic do_frame(input logic [7:0] d, input bit ack, input int mode);
        clear_mon();
        f_bits = '0; f_inh_bad = 0;
        iData = d; iSend = 1'b1;
        step();
        iSend = 1'b0; iData = 8'($urandom);
        if (oBusy !== 1'b1) f_inh_bad++;
        for (int k = 0; k < INH; k++) begin
            if (k > 0) step();
            if (oPS2_CLK_LOW !== 1'b1 || oPS2_DATA_LOW !== 1'b0) f_inh_bad++;
        end
        step();
        if (oPS2_CLK_LOW !== 1'b1 || oPS2_DATA_LOW !== 1'b1) f_inh_bad++;
        step();
        if (oPS2_CLK_LOW !== 1'b0 || oPS2_DATA_LOW !== 1'b1) f_inh_bad++;
        repeat (20) step();
        f_start = iPS2_DATA;
        for (int i = 0; i < 11; i++) begin
            if (i == 10 && ack) dev_data_low = 1'b1;
            if (mode == 1 && i == 4) begin
                repeat (HALF - 1) step();
                iData = ~d; iSend = 1'b1;
                step();
                iSend = 1'b0;
            end else begin
                repeat (HALF) step();
            end
            dev_clk_low = 1'b1;
            if (mode == 2 && i == 3) begin
                repeat (HALF / 2) step();
                Reset = 1'b0;
                step();
                f_rst_clk = oPS2_CLK_LOW; f_rst_data = oPS2_DATA_LOW; f_rst_busy = oBusy;
                Reset = 1'b1; dev_clk_low = 1'b0;
                repeat (30) step();
                return;
            end
            repeat (HALF) step();
            if (i < 10) f_bits[i] = iPS2_DATA;
            dev_clk_low = 1'b0;
            if (i == 10) dev_data_low = 1'b0;
        end
        repeat (60) step();
    endtask

    task automatic test_reset();
        Reset = 1'b0; iSend = 1'b1; iData = 8'($urandom);
        clear_mon();
        repeat (3) step();
        checks++;
        if ({oPS2_CLK_LOW, oPS2_DATA_LOW} !== 2'b00) begin
            errors++; $display("FAIL reset_lines: got %b expected 00", {oPS2_CLK_LOW, oPS2_DATA_LOW});
        end
        checks++;
        if ({oBusy, oDone, oError, oRxInhibit} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {oBusy, oDone, oError, oRxInhibit});
        end
        iSend = 1'b0; Reset = 1'b1;
        repeat (20) step();
        checks++;
        if (oBusy !== 1'b0) begin
            errors++; $display("FAIL reset_idle_busy: got %b expected 0", oBusy);
        end
    endtask

    task automatic test_send_ed();
        do_frame(8'hED, 1'b1, 0);
        checks++;
        if (f_inh_bad != 0) begin
            errors++; $display("FAIL ed_inhibit_req: bad samples %0d expected 0", f_inh_bad);
        end
        checks++;
        if ({f_bits, f_start} !== ref_frame(8'hED)) begin
            errors++; $display("FAIL ed_frame: got %b expected %b", {f_bits, f_start}, ref_frame(8'hED));
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 0) begin
            errors++; $display("FAIL ed_pulses: done %0d err %0d expected 1 0", done_cnt, err_cnt);
        end
        checks++;
        if (oBusy !== 1'b0 || busy_after != 0) begin
            errors++; $display("FAIL ed_busy_end: busy %b late %0d expected 0 0", oBusy, busy_after);
        end
    endtask

    task automatic test_parity();
        logic [7:0] vals [2];
        logic       pexp [2];
        vals[0] = 8'h00; pexp[0] = 1'b1;
        vals[1] = 8'h01; pexp[1] = 1'b0;
        for (int j = 0; j < 2; j++) begin
            do_frame(vals[j], 1'b1, 0);
            checks++;
            if (f_bits[8] !== pexp[j]) begin
                errors++; $display("FAIL parity_%02h: got %b expected %b", vals[j], f_bits[8], pexp[j]);
            end
            checks++;
            if ({f_bits, f_start} !== ref_frame(vals[j]) || done_cnt != 1) begin
                errors++; $display("FAIL parity_frame_%02h: got %b done %0d expected %b done 1",
                                   vals[j], {f_bits, f_start}, done_cnt, ref_frame(vals[j]));
            end
        end
    endtask

    task automatic test_no_ack();
        logic [7:0] d;
        d = 8'($urandom);
        do_frame(d, 1'b0, 0);
        checks++;
        if (err_cnt != 1 || done_cnt != 0) begin
            errors++; $display("FAIL noack_pulses: err %0d done %0d expected 1 0", err_cnt, done_cnt);
        end
        checks++;
        if ({oPS2_CLK_LOW, oPS2_DATA_LOW, oBusy} !== 3'b000) begin
            errors++; $display("FAIL noack_release: got %b expected 000", {oPS2_CLK_LOW, oPS2_DATA_LOW, oBusy});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        d = 8'($urandom);
        do_frame(d, 1'b1, 1);
        checks++;
        if ({f_bits, f_start} !== ref_frame(d)) begin
            errors++; $display("FAIL b2b_frame: got %b expected %b", {f_bits, f_start}, ref_frame(d));
        end
        checks++;
        if (done_cnt != 1 || busy_after != 0 || oPS2_CLK_LOW !== 1'b0) begin
            errors++; $display("FAIL b2b_single: done %0d late_busy %0d clk_low %b expected 1 0 0",
                               done_cnt, busy_after, oPS2_CLK_LOW);
        end
    endtask

    task automatic test_reset_mid();
        do_frame(8'($urandom), 1'b1, 2);
        checks++;
        if ({f_rst_clk, f_rst_data, f_rst_busy} !== 3'b000) begin
            errors++; $display("FAIL midreset_outputs: got %b expected 000", {f_rst_clk, f_rst_data, f_rst_busy});
        end
        checks++;
        if (done_cnt != 0 || err_cnt != 0) begin
            errors++; $display("FAIL midreset_pulse: done %0d err %0d expected 0 0", done_cnt, err_cnt);
        end
        do_frame(8'hFF, 1'b1, 0);
        checks++;
        if ({f_bits, f_start} !== ref_frame(8'hFF) || done_cnt != 1) begin
            errors++; $display("FAIL midreset_resend: got %b done %0d expected %b done 1",
                               {f_bits, f_start}, done_cnt, ref_frame(8'hFF));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            logic [7:0] d;
            bit         a;
            d = 8'($urandom);
            a = ($urandom_range(0, 3) != 0);
            do_frame(d, a, 0);
            checks++;
            if ({f_bits, f_start} !== ref_frame(d)) begin
                errors++; $display("FAIL rand_frame_%0d: got %b expected %b", n, {f_bits, f_start}, ref_frame(d));
            end
            checks++;
            if (done_cnt != (a ? 1 : 0) || err_cnt != (a ? 0 : 1)) begin
                errors++; $display("FAIL rand_pulses_%0d: done %0d err %0d ack %0d", n, done_cnt, err_cnt, a);
            end
        end
    endtask

    task automatic test_timeout();
        int first_err;
        clear_mon();
        first_err = -1;
        iData = 8'($urandom); iSend = 1'b1;
        step();
        iSend = 1'b0;
        for (int k = 1; k <= TMO + 50; k++) begin
            step();
            if (oError && first_err < 0) first_err = k;
        end
`ifdef PS2_TX_TIMEOUT_EN
        checks++;
        if (first_err != TMO) begin
            errors++; $display("FAIL timeout_cycle: got %0d expected %0d", first_err, TMO);
        end
        checks++;
        if ({oPS2_CLK_LOW, oPS2_DATA_LOW, oBusy} !== 3'b000 || err_cnt != 1) begin
            errors++; $display("FAIL timeout_release: got %b err %0d expected 000 err 1",
                               {oPS2_CLK_LOW, oPS2_DATA_LOW, oBusy}, err_cnt);
        end
`else
        checks++;
        if (oBusy !== 1'b1 || err_cnt != 0 || first_err != -1) begin
            errors++; $display("FAIL no_watchdog: busy %b err %0d expected busy 1 err 0", oBusy, err_cnt);
        end
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        repeat (20) step();
`endif
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_parity();
        test_no_ack();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_timeout();
        checks++;
        if (g_both != 0 || g_pbusy != 0) begin
            errors++; $display("FAIL pulse_rules: both %0d busy_at_pulse %0d expected 0 0", g_both, g_pbusy);
        end
        checks++;
        if (g_rxinh != 0) begin
            errors++; $display("FAIL rx_inhibit: differing cycles %0d expected 0", g_rxinh);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
